bp_cce_cfg_loader_mc: RTL and testbench
=======================================

# bp_cce_cfg_loader_mc

Parametrised multi-CCE boot configuration loader. It streams the CCE instruction image from a boot ROM over the config link into the instruction RAM of each of `num_cce_p` CCEs in turn. Instructions of any width are split into as many link words as needed. An optional readback-verify mode checks every word written. The block sits between the boot ROM and the config link, and holds the system frozen until every CCE is loaded and verified.

## Interface
Parameters:
- `inst_width_p`, "inv": CCE instruction width in bits.
- `inst_ram_addr_width_p`, "inv": instruction RAM address width.
- `inst_ram_els_p`, "inv": instructions per CCE. Must be ≤ 2^`inst_ram_addr_width_p`.
- `cfg_link_addr_width_p`, "inv": config link address width.
- `cfg_link_data_width_p`, "inv": config link data width.
- `num_cce_p`, 1: number of CCEs loaded in sequence.
- `verify_p`, 0: 1 = read back and compare each write.
- Derived: `words_lp` = ceil(`inst_width_p`/`cfg_link_data_width_p`); `word_bits_lp` = max(1, clog2(`words_lp`)); `cce_bits_lp` = max(1, clog2(`num_cce_p`)).
- Requirement: `word_bits_lp` + `inst_ram_addr_width_p` ≤ `cfg_link_addr_width_p`-2.

Ports:
- `clk_i`, in, 1: clock.
- `reset_i`, in, 1: reset. Asynchronous, active-high.
- `freeze_o`, out, 1: holds cores frozen until load completes.
- `done_o`, out, 1: all CCEs loaded (and verified when `verify_p`=1).
- `error_o`, out, 1: sticky readback mismatch.
- `cce_id_o`, out, `cce_bits_lp`: target CCE of the current transaction.
- `boot_rom_addr_o`, out, `inst_ram_addr_width_p`: ROM index.
- `boot_rom_data_i`, in, `inst_width_p`: ROM data. Combinational, same cycle as the address.
- `config_addr_o`, out, `cfg_link_addr_width_p`-1: config address.
- `config_data_o`, out, `cfg_link_data_width_p`: write data.
- `config_v_o`, out, 1: request valid.
- `config_w_o`, out, 1: 1 = write, 0 = read.
- `config_ready_i`, in, 1: link accepts the request.
- `config_data_i`, in, `cfg_link_data_width_p`: read response data.
- `config_v_i`, in, 1: read response valid.
- `config_ready_o`, out, 1: loader accepts the response.

## Operation
- Counters:
  - `word_r` counts 0..`words_lp`-1.
  - `inst_r` counts 0..`inst_ram_els_p`-1.
  - `cce_r` counts 0..`num_cce_p`-1.
- Outputs driven from the counters:
  - `boot_rom_addr_o` = `inst_r`.
  - `cce_id_o` = `cce_r`.
  - `config_addr_o` = MSB 1, `word_r` in bits [`word_bits_lp`-1:0], `inst_r` in the next `inst_ram_addr_width_p` bits, all other bits 0.
- Write data is `boot_rom_data_i`[`word_r`·D +: D], with D = `cfg_link_data_width_p`. In the final word, bits beyond `inst_width_p` are zero.
- States:
  - RESET: go to PAUSE on the first clock after reset release.
  - PAUSE: one idle cycle, then go to SEND.
  - SEND: `config_v_o`=1, `config_w_o`=1. On `config_ready_i`:
    - if `verify_p`=1, go to RD_REQ;
    - otherwise advance the counters, and go to DONE on the last word.
  - RD_REQ: `config_v_o`=1, `config_w_o`=0, same address, `config_data_o`=0. On `config_ready_i`, go to RD_RESP.
  - RD_RESP: `config_ready_o`=1. On `config_v_i`, compare `config_data_i` with the expected word.
    - Mismatch: set `error_o`, go to ERROR.
    - Match: advance the counters; go to SEND, or to DONE after the last word.
  - DONE: `done_o`=1, `freeze_o`=0. Terminal.
  - ERROR: `freeze_o`=1, `done_o`=0, no requests. Terminal until reset.
- Counter advance order:
  - `word_r` increments first.
  - When `word_r` wraps from `words_lp`-1, `inst_r` increments.
  - When `inst_r` wraps from `inst_ram_els_p`-1, `cce_r` increments.
  - The last word is `word_r`=`words_lp`-1, `inst_r`=`inst_ram_els_p`-1, `cce_r`=`num_cce_p`-1.
- `config_ready_o` is 0 in every state except RD_RESP. A `config_v_i` in any other state is ignored.
- Request fields stay stable while `config_v_o`=1 and `config_ready_i`=0.

## Timing
- Reset:
  - Asynchronous assertion forces state=RESET, all counters 0, `freeze_o`=1, `done_o`=0, `error_o`=0.
  - During reset: `config_v_o`, `config_w_o` and `config_ready_o` are 0. `config_addr_o` = {1, 0…}. `config_data_o` = word 0 of ROM[0].
  - Reset mid-transfer abandons the load immediately. The load restarts from CCE 0, instruction 0.
- `freeze_o` and `done_o` are registered. They change on the clock edge after the final handshake:
  - the final `config_ready_i` write acceptance when `verify_p`=0;
  - the final matching `config_v_i` when `verify_p`=1.
- Throughput with `verify_p`=0 and `config_ready_i` held at 1: one word per cycle. The first SEND cycle is 2 cycles after reset release.
- Total load time with `verify_p`=0 and no stalls: `num_cce_p`·`inst_ram_els_p`·`words_lp` SEND cycles. `done_o` rises 2 + that count cycles after reset release.
- With `verify_p`=1: each word takes at least 3 cycles (SEND, RD_REQ, RD_RESP).
- `config_v_i` may arrive in the same cycle RD_RESP is entered. It is consumed in that cycle.

## Test plan
- `inst_width_p`=80, D=64, `inst_ram_els_p`=4, `num_cce_p`=1, `verify_p`=0, ready held 1:
  - 8 writes, to addresses {1,inst,word} in order 0,1,…,7;
  - the odd writes carry ROM bits [79:64] zero-extended;
  - `freeze_o` falls in cycle 10 after reset release.
- Same configuration, `config_ready_i` toggling 1-0-1:
  - request fields are held during stalls;
  - no write is duplicated or skipped;
  - completes after 8 accepted writes.
- `num_cce_p`=3, `inst_width_p`=48, D=64:
  - `cce_id_o` steps 0→1→2 every 4 writes;
  - `config_addr_o` low fields restart at 0 for each CCE;
  - `done_o`=1 after 12 writes.
- `verify_p`=1, echoing responder, response delay 0 and 3 cycles:
  - W/R pairs to identical addresses;
  - `error_o`=0 and `done_o`=1 at the end.
- `verify_p`=1, responder corrupts bit 5 of word 3:
  - `error_o`=1 the cycle after that response;
  - no further `config_v_o`;
  - `freeze_o` stays 1.
- Reset asserted during the 3rd write of a load:
  - outputs return immediately to their reset values;
  - after release, the load restarts at address {1,0,0} and completes normally.

Source files
------------

// File: rtl/bp_cce_cfg_loader_mc.sv
`default_nettype none
// ============================================================================
// bp_cce_cfg_loader_mc: loads each CCE's instruction RAM from boot ROM over the config link
// Revision: 1.0
// ============================================================================

module bp_cce_cfg_loader_mc #(
    parameter int inst_width_p          = 80,
    parameter int inst_ram_addr_width_p = 2,
    parameter int inst_ram_els_p        = 4,
    parameter int cfg_link_addr_width_p = 8,
    parameter int cfg_link_data_width_p = 64,
    parameter int num_cce_p             = 1,
    parameter int verify_p              = 0
) (
    input  logic                                               clk_i,
    input  logic                                               reset_i,
    output logic                                               freeze_o,
    output logic                                               done_o,
    output logic                                               error_o,
    output logic [((num_cce_p > 1) ? $clog2(num_cce_p) : 1)-1:0] cce_id_o,
    output logic [inst_ram_addr_width_p-1:0]                   boot_rom_addr_o,
    input  logic [inst_width_p-1:0]                            boot_rom_data_i,
    output logic [cfg_link_addr_width_p-2:0]                   config_addr_o,
    output logic [cfg_link_data_width_p-1:0]                   config_data_o,
    output logic                                               config_v_o,
    output logic                                               config_w_o,
    input  logic                                               config_ready_i,
    input  logic [cfg_link_data_width_p-1:0]                   config_data_i,
    input  logic                                               config_v_i,
    output logic                                               config_ready_o
);

    localparam int words_lp     = (inst_width_p + cfg_link_data_width_p - 1) / cfg_link_data_width_p;
    localparam int word_bits_lp = (words_lp > 1) ? $clog2(words_lp) : 1;
    localparam int cce_bits_lp  = (num_cce_p > 1) ? $clog2(num_cce_p) : 1;
    localparam int pad_width_lp = words_lp * cfg_link_data_width_p;

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_PAUSE   = 3'd1,
        S_SEND    = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_DONE    = 3'd5,
        S_ERROR   = 3'd6
    } state_e;

    state_e                           state_r;
    logic [word_bits_lp-1:0]          word_r;
    logic [inst_ram_addr_width_p-1:0] inst_r;
    logic [cce_bits_lp-1:0]           cce_r;
    logic                             freeze_r;
    logic                             done_r;
    logic                             error_r;

    logic [word_bits_lp-1:0]          word_nxt;
    logic [inst_ram_addr_width_p-1:0] inst_nxt;
    logic [cce_bits_lp-1:0]           cce_nxt;
    logic                             word_last;
    logic                             inst_last;
    logic                             cce_last;
    logic                             last_word;

    logic [pad_width_lp-1:0]          padded_inst;
    logic [cfg_link_data_width_p-1:0] expected_word;
    logic [cfg_link_addr_width_p-2:0] cfg_addr;
    int unsigned                      word_ofs;

    assign word_last = (word_r == word_bits_lp'(words_lp - 1));
    assign inst_last = (inst_r == inst_ram_addr_width_p'(inst_ram_els_p - 1));
    assign cce_last  = (cce_r == cce_bits_lp'(num_cce_p - 1));
    assign last_word = word_last & inst_last & cce_last;

    // Word counter is the fastest-moving field, then instruction, then CCE
    always_comb begin
        word_nxt = word_r + word_bits_lp'(1);
        inst_nxt = inst_r;
        cce_nxt  = cce_r;
        if (word_last) begin
            word_nxt = '0;
            inst_nxt = inst_r + inst_ram_addr_width_p'(1);
            if (inst_last) begin
                inst_nxt = '0;
                cce_nxt  = cce_r + cce_bits_lp'(1);
            end
        end
    end

    // Zero-extend the instruction so the final link word carries no stray bits
    always_comb begin
        padded_inst = '0;
        padded_inst[inst_width_p-1:0] = boot_rom_data_i;
        word_ofs = 32'(word_r) * cfg_link_data_width_p;
        expected_word = padded_inst[word_ofs +: cfg_link_data_width_p];
    end

    always_comb begin
        cfg_addr = '0;
        cfg_addr[cfg_link_addr_width_p-2] = 1'b1;
        cfg_addr[word_bits_lp-1:0] = word_r;
        cfg_addr[word_bits_lp +: inst_ram_addr_width_p] = inst_r;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r  <= S_RESET;
            word_r   <= '0;
            inst_r   <= '0;
            cce_r    <= '0;
            freeze_r <= 1'b1;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            unique case (state_r)
                S_RESET: state_r <= S_PAUSE;
                S_PAUSE: state_r <= S_SEND;
                S_SEND: begin
                    if (config_ready_i) begin
                        if (verify_p != 0) begin
                            state_r <= S_RD_REQ;
                        end else if (last_word) begin
                            state_r  <= S_DONE;
                            freeze_r <= 1'b0;
                            done_r   <= 1'b1;
                        end else begin
                            word_r <= word_nxt;
                            inst_r <= inst_nxt;
                            cce_r  <= cce_nxt;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (config_ready_i) begin
                        state_r <= S_RD_RESP;
                    end
                end
                S_RD_RESP: begin
                    if (config_v_i) begin
                        if (config_data_i != expected_word) begin
                            state_r <= S_ERROR;
                            error_r <= 1'b1;
                        end else if (last_word) begin
                            state_r  <= S_DONE;
                            freeze_r <= 1'b0;
                            done_r   <= 1'b1;
                        end else begin
                            state_r <= S_SEND;
                            word_r  <= word_nxt;
                            inst_r  <= inst_nxt;
                            cce_r   <= cce_nxt;
                        end
                    end
                end
                S_DONE:  state_r <= S_DONE;
                S_ERROR: state_r <= S_ERROR;
                default: state_r <= S_RESET;
            endcase
        end
    end

    assign freeze_o        = freeze_r;
    assign done_o          = done_r;
    assign error_o         = error_r;
    assign cce_id_o        = cce_r;
    assign boot_rom_addr_o = inst_r;
    assign config_addr_o   = cfg_addr;
    assign config_v_o      = (state_r == S_SEND) || (state_r == S_RD_REQ);
    assign config_w_o      = (state_r == S_SEND);
    assign config_ready_o  = (state_r == S_RD_RESP);
    assign config_data_o   = (state_r == S_RD_REQ) ? '0 : expected_word;

endmodule

`default_nettype wire

// File: tb/tb_bp_cce_cfg_loader_mc.sv
`default_nettype none
// ============================================================================
// tb_bp_cce_cfg_loader_mc: directed self-checking bench for bp_cce_cfg_loader_mc
// Revision: 1.0
// ============================================================================

module tb_bp_cce_cfg_loader_mc;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    // A: 80-bit inst, 1 CCE, no verify.  B: 48-bit inst, 3 CCEs.  C: as A with verify.
    logic        a_freeze, a_done, a_error, a_cce, a_v, a_w, a_rdy, a_rdy_o;
    logic [1:0]  a_rom_addr;
    logic [79:0] a_rom;
    logic [6:0]  a_addr;
    logic [63:0] a_data;

    logic        b_freeze, b_done, b_error, b_v, b_w, b_rdy, b_rdy_o;
    logic [1:0]  b_cce, b_rom_addr;
    logic [79:0] b_rom_full;
    logic [47:0] b_rom;
    logic [6:0]  b_addr;
    logic [63:0] b_data;

    logic        c_freeze, c_done, c_error, c_cce, c_v, c_w, c_rdy, c_rdy_o, c_rv;
    logic [1:0]  c_rom_addr;
    logic [79:0] c_rom;
    logic [6:0]  c_addr;
    logic [63:0] c_data, c_rd;

    int a_writes, a_fall, b_writes, b_fall;
    int c_pairs, c_end, c_err_cyc, c_bad_cyc;

    function automatic logic [79:0] rom_f(input logic [1:0] i);
        case (i)
            2'd0:    return 80'h1111_0123456789ABCDEF;
            2'd1:    return 80'h2222_FEDCBA9876543210;
            2'd2:    return 80'h3333_0F0F0F0FA5A5A5A5;
            default: return 80'h4444_DEADBEEFCAFEF00D;
        endcase
    endfunction

    // Expected write n for the 80-bit/64-bit link configuration (two words per instruction)
    function automatic logic [6:0] a_exp_addr(input int n);
        return 7'h40 + 7'(n);
    endfunction

    function automatic logic [63:0] a_exp_data(input int n);
        logic [79:0] r;
        r = rom_f(2'(n / 2));
        return (n % 2 == 1) ? {48'h0, r[79:64]} : r[63:0];
    endfunction

    function automatic logic [6:0] b_exp_addr(input int n);
        return 7'h40 + 7'((n % 4) * 2);
    endfunction

    function automatic logic [63:0] b_exp_data(input int n);
        logic [79:0] r;
        r = rom_f(2'(n % 4));
        return {16'h0, r[47:0]};
    endfunction

    assign a_rom      = rom_f(a_rom_addr);
    assign b_rom_full = rom_f(b_rom_addr);
    assign b_rom      = b_rom_full[47:0];
    assign c_rom      = rom_f(c_rom_addr);

    bp_cce_cfg_loader_mc #(
        .inst_width_p(80), .inst_ram_addr_width_p(2), .inst_ram_els_p(4),
        .cfg_link_addr_width_p(8), .cfg_link_data_width_p(64), .num_cce_p(1), .verify_p(0)
    ) dut_a (
        .clk_i(clk), .reset_i(rst), .freeze_o(a_freeze), .done_o(a_done), .error_o(a_error),
        .cce_id_o(a_cce), .boot_rom_addr_o(a_rom_addr), .boot_rom_data_i(a_rom),
        .config_addr_o(a_addr), .config_data_o(a_data), .config_v_o(a_v), .config_w_o(a_w),
        .config_ready_i(a_rdy), .config_data_i(64'h0), .config_v_i(1'b0), .config_ready_o(a_rdy_o)
    );

    bp_cce_cfg_loader_mc #(
        .inst_width_p(48), .inst_ram_addr_width_p(2), .inst_ram_els_p(4),
        .cfg_link_addr_width_p(8), .cfg_link_data_width_p(64), .num_cce_p(3), .verify_p(0)
    ) dut_b (
        .clk_i(clk), .reset_i(rst), .freeze_o(b_freeze), .done_o(b_done), .error_o(b_error),
        .cce_id_o(b_cce), .boot_rom_addr_o(b_rom_addr), .boot_rom_data_i(b_rom),
        .config_addr_o(b_addr), .config_data_o(b_data), .config_v_o(b_v), .config_w_o(b_w),
        .config_ready_i(b_rdy), .config_data_i(64'h0), .config_v_i(1'b0), .config_ready_o(b_rdy_o)
    );

    bp_cce_cfg_loader_mc #(
        .inst_width_p(80), .inst_ram_addr_width_p(2), .inst_ram_els_p(4),
        .cfg_link_addr_width_p(8), .cfg_link_data_width_p(64), .num_cce_p(1), .verify_p(1)
    ) dut_c (
        .clk_i(clk), .reset_i(rst), .freeze_o(c_freeze), .done_o(c_done), .error_o(c_error),
        .cce_id_o(c_cce), .boot_rom_addr_o(c_rom_addr), .boot_rom_data_i(c_rom),
        .config_addr_o(c_addr), .config_data_o(c_data), .config_v_o(c_v), .config_w_o(c_w),
        .config_ready_i(c_rdy), .config_data_i(c_rd), .config_v_i(c_rv), .config_ready_o(c_rdy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        a_rdy = 1'b0;
        b_rdy = 1'b0;
        c_rdy = 1'b0;
        c_rv  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_a_reset_values(input string tag);
        check({tag, "_freeze"}, 80'(a_freeze), 80'(1));
        check({tag, "_done"}, 80'(a_done), 80'(0));
        check({tag, "_error"}, 80'(a_error), 80'(0));
        check({tag, "_v"}, 80'(a_v), 80'(0));
        check({tag, "_w"}, 80'(a_w), 80'(0));
        check({tag, "_rdy_o"}, 80'(a_rdy_o), 80'(0));
        check({tag, "_addr"}, 80'(a_addr), 80'(7'h40));
        check({tag, "_data"}, 80'(a_data), 80'(64'h0123456789ABCDEF));
        check({tag, "_rom_addr"}, 80'(a_rom_addr), 80'(0));
    endtask

    // Drives instance A's ready; every presented request must match write n until accepted
    task automatic run_a(input bit toggle, input int stop_at);
        int n = 0;
        a_fall = -1;
        for (int c = 1; c <= 60 && a_fall < 0; c++) begin
            @(posedge clk);
            #1;
            a_rdy = toggle ? c[0] : 1'b1;
            if (a_v) begin
                if (stop_at == n) return;
                check("a_w", 80'(a_w), 80'(1));
                check("a_addr", 80'(a_addr), 80'(a_exp_addr(n)));
                check("a_data", 80'(a_data), 80'(a_exp_data(n)));
                if (a_rdy) n++;
            end
            if (!a_freeze) a_fall = c;
        end
        a_writes = n;
        a_rdy = 1'b0;
    endtask

    task automatic run_b();
        int n = 0;
        b_fall = -1;
        for (int c = 1; c <= 60 && b_fall < 0; c++) begin
            @(posedge clk);
            #1;
            b_rdy = 1'b1;
            if (b_v) begin
                check("b_addr", 80'(b_addr), 80'(b_exp_addr(n)));
                check("b_data", 80'(b_data), 80'(b_exp_data(n)));
                check("b_cce", 80'(b_cce), 80'(n / 4));
                n++;
            end
            if (b_done) b_fall = c;
        end
        b_writes = n;
        b_rdy = 1'b0;
    endtask

    // Echoing responder: replies `delay` cycles into RD_RESP, optionally flipping bit 5 of read bad_idx
    task automatic run_c(input int delay, input int bad_idx, input bit spur);
        int          n = 0;
        int          rd = 0;
        int          cnt = 0;
        bit          pending = 1'b0;
        logic [63:0] last_d = '0;
        c_end = -1;
        c_err_cyc = -1;
        c_bad_cyc = -1;
        c_rdy = 1'b1;
        for (int c = 1; c <= 200 && c_end < 0 && c_err_cyc < 0; c++) begin
            @(posedge clk);
            #1;
            c_rv = 1'b0;
            c_rd = '0;
            if (c_v) check("c_rdy_o_req", 80'(c_rdy_o), 80'(0));
            if (pending) begin
                if (cnt == 0) begin
                    check("c_rdy_o_resp", 80'(c_rdy_o), 80'(1));
                    c_rv = 1'b1;
                    c_rd = last_d ^ ((rd == bad_idx) ? 64'h20 : 64'h0);
                    if (rd == bad_idx) c_bad_cyc = c;
                    rd++;
                    pending = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (c_v && c_w) begin
                check("c_wr_addr", 80'(c_addr), 80'(a_exp_addr(n)));
                check("c_wr_data", 80'(c_data), 80'(a_exp_data(n)));
                last_d = a_exp_data(n);
                n++;
                if (spur) begin
                    c_rv = 1'b1;
                    c_rd = ~last_d;
                end
            end else if (c_v) begin
                check("c_rd_addr", 80'(c_addr), 80'(a_exp_addr(n - 1)));
                check("c_rd_data", 80'(c_data), 80'(0));
                pending = 1'b1;
                cnt = delay;
            end
            if (c_done) c_end = c;
            if (c_error) c_err_cyc = c;
        end
        c_pairs = rd;
        c_rdy = 1'b0;
        c_rv = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        a_rdy = 1'b0;
        b_rdy = 1'b0;
        c_rdy = 1'b0;
        c_rv  = 1'b0;
        c_rd  = '0;
        repeat (2) @(negedge clk);

        check_a_reset_values("rst");
        check("rst_b_addr", 80'(b_addr), 80'(7'h40));
        check("rst_b_data", 80'(b_data), 80'(64'h0000_456789ABCDEF));
        check("rst_b_cce", 80'(b_cce), 80'(0));
        check("rst_c_rdy_o", 80'(c_rdy_o), 80'(0));

        // Ready held high: 8 writes back to back, freeze falls 10 cycles after release
        rst = 1'b0;
        run_a(1'b0, -1);
        check("a1_writes", 80'(a_writes), 80'(8));
        check("a1_fall_cycle", 80'(a_fall), 80'(10));
        check("a1_done", 80'(a_done), 80'(1));
        check("a1_error", 80'(a_error), 80'(0));
        check("a1_v_after", 80'(a_v), 80'(0));

        // Ready toggling: stalls must hold the request, no skip or duplicate
        do_reset();
        run_a(1'b1, -1);
        check("a2_writes", 80'(a_writes), 80'(8));
        check("a2_done", 80'(a_done), 80'(1));
        check("a2_freeze", 80'(a_freeze), 80'(0));

        // Reset during the third write, then a full clean reload
        do_reset();
        run_a(1'b0, 2);
        rst = 1'b1;
        #1;
        check_a_reset_values("mid");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_a(1'b0, -1);
        check("a3_writes", 80'(a_writes), 80'(8));
        check("a3_fall_cycle", 80'(a_fall), 80'(10));
        check("a3_done", 80'(a_done), 80'(1));

        // Three CCEs, one link word per instruction
        do_reset();
        run_b();
        check("b_writes", 80'(b_writes), 80'(12));
        check("b_done_cycle", 80'(b_fall), 80'(14));
        check("b_freeze", 80'(b_freeze), 80'(0));

        // Verify mode, zero-delay echo
        do_reset();
        run_c(0, -1, 1'b0);
        check("c0_pairs", 80'(c_pairs), 80'(8));
        check("c0_done_cycle", 80'(c_end), 80'(26));
        check("c0_error", 80'(c_error), 80'(0));
        check("c0_freeze", 80'(c_freeze), 80'(0));

        // Verify mode, 3-cycle echo delay, stray responses outside RD_RESP
        do_reset();
        run_c(3, -1, 1'b1);
        check("c3_pairs", 80'(c_pairs), 80'(8));
        check("c3_done_cycle", 80'(c_end), 80'(50));
        check("c3_error", 80'(c_error), 80'(0));

        // Corrupted readback of word 3
        do_reset();
        run_c(0, 3, 1'b0);
        check("ce_err_cycle", 80'(c_err_cyc), 80'(c_bad_cyc + 1));
        check("ce_pairs", 80'(c_pairs), 80'(4));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("ce_no_req", 80'(c_v), 80'(0));
        end
        check("ce_error", 80'(c_error), 80'(1));
        check("ce_freeze", 80'(c_freeze), 80'(1));
        check("ce_done", 80'(c_done), 80'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
